// File: rtl/dual_issue_fetch_queue.sv
// dual_issue_fetch_queue
//
// Instruction fetch stage feeding the dual-issue scheduler. It fetches
// aligned 64-bit instruction pairs from instruction memory, buffers the
// 32-bit words in a circular FIFO, and presents the two oldest words every
// cycle. On each enabled step it retires 0, 1 or 2 words, depending on the
// freeze/dependency feedback from the scheduler.
//
// Ports:
//   clk                 system clock
//   n_rst               synchronous reset, active-high
//   en                  pipeline step enable; gates pops and flush
//   freeze1             slot 0 must not retire this step
//   freeze2             slot 1 must not retire this step
//   dependency_on_ins2  slot 1 depends on slot 0; retire slot 0 only
//   flush               discard queue and redirect fetch (only with en=1)
//   redirect_pc         new fetch byte address (bits[1:0] ignored)
//   imem_req            fetch request, held until imem_gnt
//   imem_gnt            request accepted this cycle
//   imem_addr           8-byte aligned fetch address
//   imem_rvalid         response data valid
//   imem_rdata          [31:0] word at imem_addr, [63:32] word at imem_addr+4
//   instruction0        oldest queued word, 0 when the queue is empty
//   instruction1        second-oldest word, 0 when fewer than two words
//   nothing_filled      queue empty
//   count               number of occupied entries

module dual_issue_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     en,
  input  logic                     freeze1,
  input  logic                     freeze2,
  input  logic                     dependency_on_ins2,
  input  logic                     flush,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  input  logic                     imem_gnt,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [63:0]              imem_rdata,
  output logic [31:0]              instruction0,
  output logic [31:0]              instruction1,
  output logic                     nothing_filled,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // Storage and pointers
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_plus1;
  logic [PW-1:0] tail_plus1;

  // Fetch control. The fetch address is always pair-aligned, so only the
  // line number (address bits [31:3]) is kept.
  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [28:0]   fetch_line;
  logic          drop_flag;
  logic          drop_next;
  logic          skip_first;

  // Per-cycle decisions
  logic          flush_now;
  logic          accept;
  logic          has_space;
  logic [1:0]    push_num;
  logic [1:0]    pop_num;
  logic [CW-1:0] count_next;

  logic          unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign head_plus1 = head + PW'(1);
  assign tail_plus1 = tail + PW'(1);

  assign flush_now = en & flush;

  // A response lands only if it was not orphaned by an earlier flush and
  // is not being thrown away by a flush in this very cycle.
  assign accept = imem_rvalid & ~drop_flag & ~flush_now;

  // After a redirect into the upper half of a pair, the lower word of the
  // first response lies before the target and must not be queued.
  always_comb begin
    push_num = 2'd0;
    if (accept) begin
      push_num = skip_first ? 2'd1 : 2'd2;
    end
  end

  always_comb begin
    pop_num = 2'd0;
    if (en && !flush && !freeze1 && (count != '0)) begin
      if (freeze2 || dependency_on_ins2 || (count == CW'(1))) begin
        pop_num = 2'd1;
      end else begin
        pop_num = 2'd2;
      end
    end
  end

  assign count_next = count + CW'(push_num) - CW'(pop_num);

  // Uses the occupancy before this cycle's pops, so a request is only
  // issued when a full pair is guaranteed to fit on arrival.
  assign has_space = (count <= CW'(DEPTH - 2));

  // Fetch FSM: next state, drop flag and request output
  always_comb begin
    state_next = state;
    drop_next  = drop_flag;
    imem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (has_space) begin
          state_next = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_next = WAIT;
          // Granted in the flush cycle: the response belongs to the old
          // stream and has to be swallowed when it shows up.
          if (flush_now) begin
            drop_next = 1'b1;
          end
        end else if (flush_now) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_next = IDLE;
          drop_next  = 1'b0;
        end else if (flush_now) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state      <= IDLE;
      drop_flag  <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_line <= RESET_PC[31:3];
      skip_first <= 1'b0;
    end else begin
      state     <= state_next;
      drop_flag <= drop_next;
      if (flush_now) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        fetch_line <= redirect_pc[31:3];
        skip_first <= redirect_pc[2];
      end else begin
        head  <= head + PW'(pop_num);
        tail  <= tail + PW'(push_num);
        count <= count_next;
        if (accept) begin
          fetch_line <= fetch_line + 29'd1;
          skip_first <= 1'b0;
        end
      end
    end
  end

  // Word storage; contents are don't-care until covered by count
  always_ff @(posedge clk) begin
    if (!n_rst && accept) begin
      if (skip_first) begin
        mem[tail] <= imem_rdata[63:32];
      end else begin
        mem[tail]       <= imem_rdata[31:0];
        mem[tail_plus1] <= imem_rdata[63:32];
      end
    end
  end

  assign imem_addr      = {fetch_line, 3'b000};
  assign nothing_filled = (count == '0);
  assign instruction0   = (count != '0)        ? mem[head]       : 32'd0;
  assign instruction1   = (count >= CW'(2))    ? mem[head_plus1] : 32'd0;

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// tb_dual_issue_fetch_queue
//
// Self-checking bench for dual_issue_fetch_queue. A behavioural model keeps
// the expected queue contents as a word queue, tags each granted request
// with a flush epoch, and pushes the expected outputs into a scoreboard
// every clock; a monitor pops and compares them on the falling edge.
// A small memory responder serves requests with configurable latency.

module tb_dual_issue_fetch_queue;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          en = 1'b0;
  logic          freeze1 = 1'b0;
  logic          freeze2 = 1'b0;
  logic          dependency_on_ins2 = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          imem_req;
  logic          imem_gnt = 1'b0;
  logic [31:0]   imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [63:0]   imem_rdata = 64'd0;
  logic [31:0]   instruction0;
  logic [31:0]   instruction1;
  logic          nothing_filled;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  dual_issue_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .en                 (en),
    .freeze1            (freeze1),
    .freeze2            (freeze2),
    .dependency_on_ins2 (dependency_on_ins2),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .imem_req           (imem_req),
    .imem_gnt           (imem_gnt),
    .imem_addr          (imem_addr),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .instruction0       (instruction0),
    .instruction1       (instruction1),
    .nothing_filled     (nothing_filled),
    .count              (count)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Instruction memory contents: the first two pairs hold a short program,
  // everything else is a hash of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h002081B3;
      32'hC:   return 32'h00000013;
      default: return (a * 32'h9E3779B1) ^ 32'hC0DE0001;
    endcase
  endfunction

  // Memory responder
  bit          gnt_always  = 1'b1;
  int          lat_cfg     = 1;
  int          grant_limit = 0;
  int          grant_cnt   = 0;
  int          mem_timer   = 0;
  logic [31:0] mem_raddr   = 32'd0;
  logic [31:0] last_grant  = 32'd0;

  initial begin
    forever begin
      @(posedge clk);
      if (n_rst) begin
        mem_timer = 0;
      end else begin
        if (mem_timer > 0) mem_timer--;
        if (imem_req && imem_gnt) begin
          mem_raddr  = imem_addr;
          last_grant = imem_addr;
          grant_cnt++;
          mem_timer  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
        end
      end
      @(negedge clk);
      imem_rvalid = (mem_timer == 1);
      if (mem_timer == 1) begin
        imem_rdata = {word_at(mem_raddr + 32'd4), word_at(mem_raddr)};
      end else begin
        imem_rdata = {$urandom, $urandom};
      end
      imem_gnt = imem_req && (grant_cnt < grant_limit) &&
                 (gnt_always || ($urandom_range(0, 1) == 1));
    end
  end

  // Reference model and scoreboard
  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    int          cnt;
    bit          empty;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  logic [31:0] m_pc    = RESET_PC;
  bit          m_skip  = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_paddr = 32'd0;
  int          m_epoch = 0;
  int          m_pepoch = 0;
  bit          m_fl;
  bit          m_take;
  int          m_sz;
  int          m_npop;
  exp_t        m_exp;

  initial begin
    forever begin
      @(posedge clk);
      if (n_rst) begin
        mq.delete();
        m_pc   = RESET_PC;
        m_skip = 1'b0;
        m_pend = 1'b0;
        m_epoch++;
      end else begin
        m_fl   = en && flush;
        m_sz   = mq.size();
        m_take = 1'b0;
        m_npop = 0;
        if (imem_rvalid) begin
          checkOutput("rvalid_has_request", 32'(m_pend), 32'd1);
          if (m_pend && !m_fl && (m_pepoch == m_epoch)) m_take = 1'b1;
          m_pend = 1'b0;
        end
        if (imem_req && imem_gnt) begin
          checkOutput("single_outstanding", 32'(m_pend), 32'd0);
          checkOutput("request_addr", imem_addr, {m_pc[31:3], 3'b000});
          checkOutput("space_at_grant", 32'(m_sz <= DEPTH - 2), 32'd1);
          m_pend   = 1'b1;
          m_paddr  = {m_pc[31:3], 3'b000};
          m_pepoch = m_epoch;
        end
        if (en && !m_fl && !freeze1 && m_sz > 0) begin
          m_npop = (freeze2 || dependency_on_ins2 || m_sz == 1) ? 1 : 2;
        end
        repeat (m_npop) void'(mq.pop_front());
        if (m_take) begin
          if (!m_skip) mq.push_back(word_at(m_paddr));
          mq.push_back(word_at(m_paddr + 32'd4));
          m_skip = 1'b0;
          m_pc   = m_pc + 32'd8;
        end
        if (m_fl) begin
          mq.delete();
          m_pc   = redirect_pc;
          m_skip = redirect_pc[2];
          m_epoch++;
        end
      end
      m_exp.cnt   = mq.size();
      m_exp.empty = (mq.size() == 0);
      m_exp.i0    = (mq.size() > 0) ? mq[0] : 32'd0;
      m_exp.i1    = (mq.size() > 1) ? mq[1] : 32'd0;
      sb.push_back(m_exp);
    end
  end

  // Monitor
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput("instruction0", instruction0, mon_e.i0);
        checkOutput("instruction1", instruction1, mon_e.i1);
        checkOutput("count", 32'(count), 32'(mon_e.cnt));
        checkOutput("nothing_filled", 32'(nothing_filled), 32'(mon_e.empty));
      end
    end
  end

  // Stimulus helpers
  task automatic applyStimulus(input bit e, input bit f1, input bit f2,
                               input bit dep, input bit fl, input logic [31:0] rpc);
    en                 = e;
    freeze1            = f1;
    freeze2            = f2;
    dependency_on_ins2 = dep;
    flush              = fl;
    redirect_pc        = rpc;
    @(negedge clk);
    en                 = 1'b0;
    freeze1            = 1'b0;
    freeze2            = 1'b0;
    dependency_on_ins2 = 1'b0;
    flush              = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitGrant(input int start, input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (grant_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  bit seen;
  int start_cnt;

  initial begin
    // Reset
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_imem_req", 32'(imem_req), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_nothing_filled", 32'(nothing_filled), 32'd1);
    checkOutput("reset_instruction0", instruction0, 32'd0);
    n_rst = 1'b0;

    // Two pairs with single-cycle latency
    waitCycles(4);
    checkOutput("prefill_nothing_filled", 32'(nothing_filled), 32'd1);
    checkOutput("prefill_instruction1", instruction1, 32'd0);
    grant_limit = grant_cnt + 2;
    waitCycles(12);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_instruction0", instruction0, 32'h00500093);
    checkOutput("fill_instruction1", instruction1, 32'h00100113);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("dual_pop_count", 32'(count), 32'd2);
    checkOutput("dual_pop_instruction0", instruction0, 32'h002081B3);

    // Freeze and dependency handling
    grant_limit = grant_cnt + 1;
    waitCycles(8);
    checkOutput("refill_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("freeze1_count", 32'(count), 32'd4);
    checkOutput("freeze1_instruction0", instruction0, word_at(32'h8));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("freeze2_count", 32'(count), 32'd3);
    checkOutput("freeze2_instruction0", instruction0, word_at(32'hC));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("dependency_count", 32'(count), 32'd2);
    checkOutput("dependency_instruction0", instruction0, word_at(32'h10));

    // Fill to DEPTH with memory always ready, then wrap the pointers
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    grant_limit = grant_cnt + 100;
    waitCycles(30);
    checkOutput("full_count", 32'(count), 32'(DEPTH));
    for (int k = 0; k < 5; k++) begin
      checkOutput("full_no_request", 32'(imem_req), 32'd0);
      waitCycles(1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("full_pop_count", 32'(count), 32'(DEPTH - 2));
    waitCycles(10);
    checkOutput("refull_count", 32'(count), 32'(DEPTH));
    for (int k = 0; k < 40; k++) begin
      applyStimulus(bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    1'b0, 32'd0);
    end
    waitCycles(30);
    checkOutput("wrap_full_count", 32'(count), 32'(DEPTH));

    // Flush during WAIT with a slow response
    lat_cfg     = 3;
    grant_limit = grant_cnt + 1;
    start_cnt   = grant_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    waitGrant(start_cnt, 20, seen);
    checkOutput("slow_grant_seen", 32'(seen), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    checkOutput("flush_wait_count", 32'(count), 32'd0);
    lat_cfg     = 1;
    grant_limit = grant_cnt + 1;
    waitCycles(12);
    checkOutput("redirect_grant_addr", last_grant, 32'h40);
    checkOutput("redirect_count", 32'(count), 32'd2);
    checkOutput("redirect_instruction0", instruction0, word_at(32'h40));

    // Flush into the upper half of a pair
    grant_limit = grant_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
    grant_limit = grant_cnt + 1;
    waitCycles(10);
    checkOutput("skip_grant_addr", last_grant, 32'h40);
    checkOutput("skip_count", 32'(count), 32'd1);
    checkOutput("skip_instruction0", instruction0, word_at(32'h44));
    checkOutput("skip_instruction1", instruction1, 32'd0);
    checkOutput("skip_next_req", 32'(imem_req), 32'd1);
    checkOutput("skip_next_addr", imem_addr, 32'h48);

    // Single pop from count==1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("last_pop_nothing_filled", 32'(nothing_filled), 32'd1);

    // Single pop coinciding with a response
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
    grant_limit = grant_cnt + 1;
    waitCycles(10);
    checkOutput("second_skip_count", 32'(count), 32'd1);
    lat_cfg     = 2;
    grant_limit = grant_cnt + 1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (imem_rvalid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("overlap_rvalid_seen", 32'(seen), 32'd1);
    if (seen) begin
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      checkOutput("overlap_count", 32'(count), 32'd2);
      checkOutput("overlap_instruction0", instruction0, word_at(32'h48));
    end

    // Randomized traffic with one mid-run reset
    gnt_always  = 1'b0;
    lat_cfg     = 0;
    grant_limit = grant_cnt + 100000;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        n_rst = 1'b1;
        waitCycles(2);
        n_rst = 1'b0;
      end
      applyStimulus(bit'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 24) == 0, $urandom);
    end
    waitCycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dual_issue_fetch_queue.md
Name: dual_issue_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the scheduling/control stage; replaces the fixed instruction source that drives `instruction0`/`instruction1`.
- Fetches aligned 64-bit instruction pairs from instruction memory over a req/rvalid handshake.
- Buffers the fetched words in a circular FIFO.
- Presents the two oldest words each cycle and retires 0, 1 or 2 of them per enabled cycle, according to the freeze/dependency signals from the scheduler.

Parameters:
- DEPTH, 8, FIFO entries (32-bit words); power of 2, ≥4
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; 8-byte aligned

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- en  in  1  pipeline step enable (1 Hz tick); gates pops and flush
- freeze1  in  1  slot 0 must not retire this step
- freeze2  in  1  slot 1 must not retire this step
- dependency_on_ins2  in  1  slot 1 depends on slot 0; retire slot 0 only
- flush  in  1  discard queue and redirect fetch (sampled only when en=1)
- redirect_pc  in  32  new fetch byte address; bits[1:0] ignored
- imem_req  out  1  fetch request, held until accepted
- imem_gnt  in  1  request accepted this cycle
- imem_addr  out  32  8-byte aligned fetch address
- imem_rvalid  in  1  response data valid
- imem_rdata  in  64  [31:0] = word at imem_addr, [63:32] = word at imem_addr+4
- instruction0  out  32  oldest queued word, or 32'd0 if empty
- instruction1  out  32  second-oldest word, or 32'd0 if count<2
- nothing_filled  out  1  queue empty (count==0)
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (clk edge with n_rst=1):
  - head=tail=count=0
  - fetch_pc=RESET_PC, imem_req=0
  - no outstanding request, drop flag clear, skip_first clear
  - outputs: instruction0=instruction1=0, nothing_filled=1, count=0
- Storage: circular array DEPTH×32. head and tail wrap modulo DEPTH. Outputs are combinational from the array at head and head+1 (mod DEPTH), masked to 0 when not valid.
- Fetch FSM states:
  - IDLE → REQ when no request is outstanding and (DEPTH − count) ≥ 2.
  - REQ: imem_req=1, imem_addr={fetch_pc[31:3],3'b0}; addr and req held stable until imem_gnt. On gnt → WAIT.
  - WAIT: on imem_rvalid → IDLE.
  - At most one request is outstanding.
  - The space check uses count before same-cycle pops (conservative).
- Response push (every clk, independent of en), when imem_rvalid and drop flag clear:
  - skip_first=0: write both words at tail, tail+1; tail+=2, count+=2.
  - skip_first=1: write only [63:32]; tail+=1, count+=1; clear skip_first.
  - In both cases fetch_pc += 8.
- Drop flag set: response discarded, flag cleared, fetch_pc unchanged.
- Pop rule (only when en=1 and flush=0):
  - freeze1=1 → pop 0.
  - else freeze2=1 or dependency_on_ins2=1 or count==1 → pop 1.
  - else count≥2 → pop 2.
  - count==0 → pop 0.
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. Never exceeds DEPTH, never underflows.
- Flush (en=1 and flush=1) overrides pop and push that cycle:
  - head=tail=count=0; fetch_pc={redirect_pc[31:3],3'b0}; skip_first=redirect_pc[2].
  - In WAIT, or in REQ with gnt the same cycle: set the drop flag so the in-flight response is discarded; the FSM still waits for that rvalid before re-requesting.
  - In REQ without gnt: drop imem_req (return to IDLE); no drop flag.
  - rvalid in the same cycle as flush is discarded.
- flush with en=0 is ignored.
- Reset mid-request abandons the transaction. The memory is reset by the same n_rst, so no stale rvalid is expected.
- fetch_pc wraps naturally at 2^32.

Test Plan:
- Reset, memory returns pairs {0x00500093, 0x00100113}, {0x002081B3, 0x00000013} with 1-cycle latency:
  - before fill: nothing_filled=1, instruction0=instruction1=0;
  - after both responses: count=4, instruction0=0x00500093, instruction1=0x00100113;
  - en pulse with no freezes → count=2, instruction0=0x002081B3.
- Queue holds 4 words, en with freeze1=1 → count stays 4, outputs unchanged. en with freeze2=1 → count=3, head advanced by one. en with dependency_on_ins2=1 → count=2.
- Memory always ready, en=0:
  - queue fills to DEPTH=8 (four requests);
  - no fifth imem_req while count≥7;
  - one dual pop → request resumes, count returns to 8;
  - head/tail wrap verified by the word sequence continuing in address order.
- Request granted, rvalid delayed 3 cycles, flush with redirect_pc=0x40 during WAIT:
  - count=0 immediately;
  - delayed response discarded;
  - next imem_addr=0x40;
  - data from 0x40 appears at instruction0.
- flush with redirect_pc=0x44:
  - imem_addr=0x40;
  - only word 0x44 is pushed (count=1);
  - instruction0 = word at 0x44, instruction1 = 0;
  - the next request is at 0x48.
- count=1, en with no freezes → pop exactly 1, nothing_filled=1 the next cycle. Same cycle with rvalid → count=2.
